// File: rtl/ex_mem_stage.sv
// Purpose : EX/MEM boundary - finishes the integer ALU, registers the result
//           with control/side-band fields, exports the head entry for forwarding.
// Latency : 1 cycle from accept to o_* (o_mem_valid = 1).
// Backpressure: two-entry skid (HEAD + SKID); o_ex_ready = !skid_valid, taken
//           from registered state only, so a stall costs no throughput.
//
// Ports:
//   i_clk, i_rst_n, i_flush        clock, async active-low reset, kill entries
//   i_ex_valid / o_ex_ready        EX-side handshake
//   i_alu_op, i_op_a, i_op_b       ALU select and operands
//   i_sll/srl/sra_result           barrel-shifter results for the same operands
//   i_pc, i_rd_addr, i_rd_wren,
//   i_mem_wren, i_mem_rden,
//   i_store_data, i_wb_sel         side-band fields carried with the result
//   o_mem_valid / i_mem_ready      MEM-side handshake
//   o_alu_data ... o_wb_sel        registered HEAD fields
//   o_fwd_valid/rd_addr/data       forwarding view of HEAD
module ex_mem_stage (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic [3:0]  i_alu_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [31:0] i_sll_result,
  input  logic [31:0] i_srl_result,
  input  logic [31:0] i_sra_result,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  input  logic        i_mem_wren,
  input  logic        i_mem_rden,
  input  logic [31:0] i_store_data,
  input  logic [1:0]  i_wb_sel,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_pc,
  output logic [31:0] o_store_data,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  output logic [1:0]  o_wb_sel,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd_addr,
  output logic [31:0] o_fwd_data
);

  typedef struct packed {
    logic [31:0] alu_data;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_wren;
    logic        mem_wren;
    logic        mem_rden;
    logic [1:0]  wb_sel;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  ent_t        head_q, skid_q, in_ent;
  logic [31:0] alu_res;
  logic        head_vld, skid_vld;
  logic        accept, drain;
  logic        ld_head_in, ld_skid_in, ld_head_skid;

  // ---------------------------------------------------------------- ALU
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      4'd0:    alu_res = i_op_a + i_op_b;
      4'd1:    alu_res = i_op_a - i_op_b;
      4'd2:    alu_res = i_sll_result;
      4'd3:    alu_res = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
      4'd4:    alu_res = {31'd0, i_op_a < i_op_b};
      4'd5:    alu_res = i_op_a ^ i_op_b;
      4'd6:    alu_res = i_srl_result;
      4'd7:    alu_res = i_sra_result;
      4'd8:    alu_res = i_op_a | i_op_b;
      4'd9:    alu_res = i_op_a & i_op_b;
      4'd10:   alu_res = i_op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    in_ent            = '0;
    in_ent.alu_data   = alu_res;
    in_ent.pc         = i_pc;
    in_ent.store_data = i_store_data;
    in_ent.rd_addr    = i_rd_addr;
    in_ent.rd_wren    = i_rd_wren;
    in_ent.mem_wren   = i_mem_wren;
    in_ent.mem_rden   = i_mem_rden;
    in_ent.wb_sel     = i_wb_sel;
  end

  // ---------------------------------------------------------------- handshake
  assign head_vld   = (state != EMPTY);
  assign skid_vld   = (state == FULL);
  assign o_ex_ready = !skid_vld;
  assign accept     = i_ex_valid && o_ex_ready;
  assign drain      = head_vld && i_mem_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Flush wins over everything; no data register is touched on a flush so
  // idle entries keep their last contents.
  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_skid_in   = 1'b0;
    ld_head_skid = 1'b0;
    if (i_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            ld_head_in = 1'b1;
            state_nxt  = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            ld_head_in = 1'b1;
          end else if (accept) begin
            ld_skid_in = 1'b1;
            state_nxt  = FULL;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            ld_head_skid = 1'b1;
            state_nxt    = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------- storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_head_in)        head_q <= in_ent;
      else if (ld_head_skid) head_q <= skid_q;
      if (ld_skid_in)        skid_q <= in_ent;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_mem_valid  = head_vld;
  assign o_alu_data   = head_q.alu_data;
  assign o_pc         = head_q.pc;
  assign o_store_data = head_q.store_data;
  assign o_rd_addr    = head_q.rd_addr;
  assign o_wb_sel     = head_q.wb_sel;
  // Side-effecting controls are masked so a stale head can never act.
  assign o_rd_wren    = head_vld && head_q.rd_wren;
  assign o_mem_wren   = head_vld && head_q.mem_wren;
  assign o_mem_rden   = head_vld && head_q.mem_rden;

  assign o_fwd_valid   = o_mem_valid && o_rd_wren && (o_rd_addr != 5'd0);
  assign o_fwd_rd_addr = o_rd_addr;
  assign o_fwd_data    = o_alu_data;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_ex_valid;
  logic        o_ex_ready;
  logic [3:0]  i_alu_op;
  logic [31:0] i_op_a, i_op_b;
  logic [31:0] i_sll_result, i_srl_result, i_sra_result;
  logic [31:0] i_pc;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren, i_mem_wren, i_mem_rden;
  logic [31:0] i_store_data;
  logic [1:0]  i_wb_sel;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_alu_data, o_pc, o_store_data;
  logic [4:0]  o_rd_addr;
  logic        o_rd_wren, o_mem_wren, o_mem_rden;
  logic [1:0]  o_wb_sel;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_rd_addr;
  logic [31:0] o_fwd_data;

  ex_mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready),
    .i_alu_op(i_alu_op), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .i_sll_result(i_sll_result), .i_srl_result(i_srl_result), .i_sra_result(i_sra_result),
    .i_pc(i_pc), .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren),
    .i_mem_wren(i_mem_wren), .i_mem_rden(i_mem_rden),
    .i_store_data(i_store_data), .i_wb_sel(i_wb_sel),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_alu_data(o_alu_data), .o_pc(o_pc), .o_store_data(o_store_data),
    .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren), .o_mem_wren(o_mem_wren),
    .o_mem_rden(o_mem_rden), .o_wb_sel(o_wb_sel),
    .o_fwd_valid(o_fwd_valid), .o_fwd_rd_addr(o_fwd_rd_addr), .o_fwd_data(o_fwd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] alu, pc, sd;
    logic [4:0]  rd;
    logic        rdw, mw, mr;
    logic [1:0]  wb;
  } ent_t;

  ent_t q[$];   // reference FIFO, front = entry on o_*
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [31:0] sll, srl, sra);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd1:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd2:  return sll;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return srl;
      4'd7:  return sra;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic rand_inputs();
    i_alu_op     = 4'($urandom_range(0, 15));
    i_op_a       = $urandom;
    i_op_b       = $urandom;
    i_sll_result = $urandom;
    i_srl_result = $urandom;
    i_sra_result = $urandom;
    i_pc         = $urandom;
    i_rd_addr    = 5'($urandom);
    i_rd_wren    = 1'($urandom);
    i_mem_wren   = 1'($urandom);
    i_mem_rden   = 1'($urandom);
    i_store_data = $urandom;
    i_wb_sel     = 2'($urandom);
  endtask

  task automatic check_outputs();
    chk("mem_valid", {31'd0, o_mem_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("alu_data",   o_alu_data,   q[0].alu);
      chk("pc",         o_pc,         q[0].pc);
      chk("store_data", o_store_data, q[0].sd);
      chk("rd_addr",    {27'd0, o_rd_addr}, {27'd0, q[0].rd});
      chk("rd_wren",    {31'd0, o_rd_wren},  {31'd0, q[0].rdw});
      chk("mem_wren",   {31'd0, o_mem_wren}, {31'd0, q[0].mw});
      chk("mem_rden",   {31'd0, o_mem_rden}, {31'd0, q[0].mr});
      chk("wb_sel",     {30'd0, o_wb_sel},   {30'd0, q[0].wb});
      chk("fwd_valid",  {31'd0, o_fwd_valid}, {31'd0, q[0].rdw && (q[0].rd != 5'd0)});
      chk("fwd_rd",     {27'd0, o_fwd_rd_addr}, {27'd0, q[0].rd});
      chk("fwd_data",   o_fwd_data, q[0].alu);
    end else begin
      chk("idle_rd_wren",  {31'd0, o_rd_wren},  32'd0);
      chk("idle_mem_wren", {31'd0, o_mem_wren}, 32'd0);
      chk("idle_mem_rden", {31'd0, o_mem_rden}, 32'd0);
      chk("idle_fwd",      {31'd0, o_fwd_valid}, 32'd0);
    end
  endtask

  // One clock with the currently driven inputs; model advances at the edge.
  task automatic cycle();
    ent_t e;
    bit   rdy, acc, drn;
    rdy = q.size() < 2;
    chk("ex_ready", {31'd0, o_ex_ready}, {31'd0, rdy});
    acc = i_ex_valid && rdy;
    drn = (q.size() > 0) && i_mem_ready;
    e.alu = ref_alu(i_alu_op, i_op_a, i_op_b, i_sll_result, i_srl_result, i_sra_result);
    e.pc  = i_pc;  e.sd = i_store_data; e.rd = i_rd_addr;
    e.rdw = i_rd_wren; e.mw = i_mem_wren; e.mr = i_mem_rden; e.wb = i_wb_sel;
    @(posedge i_clk);
    if (i_flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                          input logic [31:0] sra, input logic [31:0] exp);
    rand_inputs();
    i_ex_valid = 1'b1; i_mem_ready = 1'b1; i_flush = 1'b0;
    i_alu_op = op; i_op_a = a; i_op_b = b; i_sra_result = sra;
    cycle();
    chk(tag, o_alu_data, exp);
  endtask

  task automatic check_reset_values();
    chk("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
    chk("rst_fwd_valid", {31'd0, o_fwd_valid}, 32'd0);
    chk("rst_ex_ready",  {31'd0, o_ex_ready},  32'd1);
    chk("rst_alu",       o_alu_data,   32'd0);
    chk("rst_pc",        o_pc,         32'd0);
    chk("rst_sd",        o_store_data, 32'd0);
    chk("rst_ctrl",      {25'd0, o_rd_addr, o_rd_wren, o_mem_wren, o_mem_rden}, 32'd0);
    chk("rst_wb",        {30'd0, o_wb_sel}, 32'd0);
  endtask

  initial begin
    // ---- reset
    i_rst_n = 1'b0; i_flush = 1'b0; i_ex_valid = 1'b0; i_mem_ready = 1'b0;
    rand_inputs();
    #1;
    check_reset_values();
    @(posedge i_clk); @(posedge i_clk);
    #1;
    check_reset_values();
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // ---- ALU select directed
    alu_case("alu_add_wrap", 4'd0,  32'h7FFF_FFFF, 32'd1, 32'd0, 32'h8000_0000);
    alu_case("alu_slt",      4'd3,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    alu_case("alu_sltu",     4'd4,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    alu_case("alu_sra",      4'd7,  32'd5, 32'd9, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    alu_case("alu_op13",     4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0);
    alu_case("alu_sub_wrap", 4'd1,  32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF);
    alu_case("alu_lui",      4'd10, 32'h1111_1111, 32'hABCD_E000, 32'd0, 32'hABCD_E000);

    // ---- streaming: 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b1; i_flush = 1'b0;
      cycle();
    end

    // ---- stall 3 cycles while streaming
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b0;
      cycle();
    end
    chk("stall_depth", 32'(q.size()), 32'd2);
    chk("stall_ready", {31'd0, o_ex_ready}, 32'd0);
    i_ex_valid = 1'b0; i_mem_ready = 1'b1;
    cycle();
    chk("drain1_valid", {31'd0, o_mem_valid}, 32'd1);
    cycle();
    chk("drain2_empty", {31'd0, o_mem_valid}, 32'd0);

    // ---- flush in FULL together with a new input
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b0;
      cycle();
    end
    rand_inputs(); i_ex_valid = 1'b1; i_flush = 1'b1;
    cycle();
    i_flush = 1'b0; i_ex_valid = 1'b0;
    chk("flush_valid", {31'd0, o_mem_valid}, 32'd0);
    chk("flush_ready", {31'd0, o_ex_ready}, 32'd1);
    chk("flush_ctrl",  {29'd0, o_rd_wren, o_mem_wren, o_mem_rden}, 32'd0);
    cycle();

    // ---- forwarding
    rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b1;
    i_alu_op = 4'd0; i_rd_addr = 5'd0; i_rd_wren = 1'b1;
    cycle();
    chk("fwd_x0", {31'd0, o_fwd_valid}, 32'd0);
    rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b1;
    i_alu_op = 4'd0; i_op_a = 32'd3; i_op_b = 32'd4; i_rd_addr = 5'd5; i_rd_wren = 1'b1;
    cycle();
    chk("fwd_x5_valid", {31'd0, o_fwd_valid}, 32'd1);
    chk("fwd_x5_rd",    {27'd0, o_fwd_rd_addr}, 32'd5);
    chk("fwd_x5_data",  o_fwd_data, 32'd7);

    // ---- async reset mid-stall
    for (int i = 0; i < 2; i++) begin
      rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b0;
      cycle();
    end
    chk("pre_reset_full", {31'd0, o_ex_ready}, 32'd0);
    i_rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_values();
    #2 i_rst_n = 1'b1;
    rand_inputs(); i_ex_valid = 1'b1; i_mem_ready = 1'b1;
    cycle();
    chk("post_reset_valid", {31'd0, o_mem_valid}, 32'd1);
    i_ex_valid = 1'b0;
    cycle();

    // ---- random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      i_ex_valid  = 1'($urandom_range(0, 3) != 0);
      i_mem_ready = 1'($urandom_range(0, 2) != 0);
      i_flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    i_flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory boundary stage of the pipelined RISC-V core. It consumes the three shift results produced by the barrel shifter, computes the remaining integer ALU operations and selects the final ALU result. It then registers that result, with the instruction's control and side-band fields, into the EX/MEM pipeline register. A valid/ready handshake with a two-entry skid buffer makes downstream back-pressure cost no throughput, and the head entry is exported to the forwarding path.

## Interface
Parameters: none; all widths are fixed by RV32I.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_flush  in  1  kill all entries held in this stage (branch redirect / trap)
- i_ex_valid  in  1  EX presents an instruction
- o_ex_ready  out  1  stage can accept an instruction this cycle
- i_alu_op  in  4  ALU operation select (encoding under Operation)
- i_op_a, i_op_b  in  32  ALU operands, after forwarding
- i_sll_result, i_srl_result, i_sra_result  in  32  barrel-shifter outputs for the same operands
- i_pc  in  32  instruction PC
- i_rd_addr  in  5  destination register
- i_rd_wren  in  1  instruction writes rd
- i_mem_wren, i_mem_rden  in  1  store / load
- i_store_data  in  32  rs2 value for stores
- i_wb_sel  in  2  writeback source select, carried through unchanged
- o_mem_valid  out  1  MEM-facing entry is valid
- i_mem_ready  in  1  MEM accepts the entry this cycle
- o_alu_data, o_pc, o_store_data  out  32  registered fields
- o_rd_addr  out  5  registered field
- o_rd_wren, o_mem_wren, o_mem_rden  out  1  registered fields
- o_wb_sel  out  2  registered field
- o_fwd_valid  out  1  head entry will write a nonzero rd
- o_fwd_rd_addr  out  5  forwarding destination register
- o_fwd_data  out  32  forwarding value

## Operation
- **ALU op encoding:** 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (pass i_op_b); codes 11–15 give 0.
- **Shift results:** SLL, SRL and SRA take the corresponding i_*_result input directly.
- **Arithmetic width:** ADD and SUB wrap modulo 2^32.
- **Compare results:** SLT is a signed compare and SLTU an unsigned compare; both return 32'h0000_0001 or 32'h0000_0000.
- **Storage:** two entries, HEAD (drives o_*) and SKID, each with its own valid bit.
- **Accept:** an input is accepted when `i_ex_valid && o_ex_ready`.
- **Drain:** the head is drained when `o_mem_valid && i_mem_ready`.
- **Buffer states:**
  - EMPTY (head invalid, skid invalid):
    - accept → HEAD loaded, go to ONE.
  - ONE (head valid, skid invalid):
    - accept with drain → HEAD reloaded, stay in ONE.
    - accept without drain → SKID loaded, go to FULL.
    - drain without accept → go to EMPTY.
  - FULL (head valid, skid valid):
    - o_ex_ready = 0.
    - drain → SKID moves to HEAD, go to ONE.
- **Ready:** o_ex_ready = !skid_valid, registered state only; no combinational path from i_mem_ready.
- **Flush:** i_flush clears both valid bits next edge (state → EMPTY); an input accepted in the same cycle is dropped; flush has priority over accept and drain.
- **Data fields when idle:** data registers of invalid entries hold their last value. Only o_mem_valid qualifies them, except o_rd_wren, o_mem_wren and o_mem_rden, which are forced to 0 whenever the head is invalid.
- **Forwarding outputs:**
  - o_fwd_valid = o_mem_valid && o_rd_wren && (o_rd_addr != 0).
  - o_fwd_rd_addr = o_rd_addr.
  - o_fwd_data = o_alu_data.

## Timing
- **Latency:** an input accepted at edge N appears on o_* after edge N with o_mem_valid = 1 (1-cycle latency).
- **Throughput:** one instruction per cycle while i_mem_ready = 1.
- **Back-pressure:** on the first stall cycle the stage absorbs one extra instruction into SKID. o_ex_ready falls one cycle after the stall begins and rises the cycle after the first drain.
- **Ordering:** strictly FIFO, with no loss or duplication.
- **Reset (i_rst_n = 0, asynchronous):**
  - o_mem_valid, o_fwd_valid = 0.
  - All o_* data outputs = 0, all control outputs = 0.
  - o_ex_ready = 1 both during and after reset.
- **Reset mid-operation:** reset discards both entries immediately, without waiting for a clock edge.

## Test plan
- **ALU select:**
  - ADD 0x7FFF_FFFF + 1 → o_alu_data 0x8000_0000.
  - SLT -1 < 1 → 1.
  - SLTU 0xFFFF_FFFF < 1 → 0.
  - SRA with i_sra_result 0xFFFF_FFF8 → 0xFFFF_FFF8.
  - op 13 → 0.
- **Streaming:** 8 back-to-back instructions with i_mem_ready = 1 → each appears 1 cycle later, o_ex_ready stays 1, order preserved.
- **Stall:**
  - Hold i_mem_ready = 0 for 3 cycles while streaming → stage holds exactly 2 instructions and o_ex_ready = 0.
  - Release i_mem_ready → both drain in order on consecutive cycles, no loss.
- **Flush in FULL:** assert i_flush together with i_ex_valid → next cycle o_mem_valid = 0, o_ex_ready = 1, the new input is not emitted, and control outputs are 0.
- **Forwarding:**
  - rd = x0 with i_rd_wren = 1 → o_fwd_valid = 0.
  - rd = x5, ADD 3 + 4 → o_fwd_valid = 1, o_fwd_rd_addr = 5, o_fwd_data = 7.
- **Asynchronous reset mid-stall:** with the stage FULL, drop i_rst_n between edges → outputs go to reset values immediately; after release the first accepted instruction emerges correctly.
